// File: rtl/game_timer_ctrl.sv
// Round/timer sequencer: level countdown from a clock-enable tick, lives and level
// tracking, and round-robin arbitration of bonus-time requests.
module game_timer_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int INIT_TIME  = 60,
  parameter int BONUS_TIME = 5,
  parameter int MAX_TIME   = 999,
  parameter int INIT_LIVES = 3,
  parameter int NUM_REQ    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               level_done,
  input  logic [NUM_REQ-1:0] bonus_req,
  output logic [NUM_REQ-1:0] bonus_ack,
  output logic [9:0]         lvl,
  output logic [11:0]        counter,
  output logic [3:0]         lives,
  output logic               time_out,
  output logic               lvl_changed,
  output logic               game_over,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_RUNNING      = 3'd1,
    S_PAUSED       = 3'd2,
    S_LEVEL_UP     = 3'd3,
    S_WAIT_RESPAWN = 3'd4,
    S_GAME_OVER    = 3'd5
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [11:0]   INIT_CNT   = 12'(INIT_TIME);
  localparam logic [12:0]   MAX_CNT    = 13'(MAX_TIME);
  localparam logic [12:0]   BONUS_CNT  = 13'(BONUS_TIME);
  localparam logic [3:0]    INIT_LIV   = 4'(INIT_LIVES);

  state_t             state_reg, state_next;
  logic [PW-1:0]      presc_reg, presc_next;
  logic [11:0]        counter_reg, counter_next;
  logic [9:0]         lvl_reg, lvl_next;
  logic [3:0]         lives_reg, lives_next;
  logic [RW-1:0]      ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               time_out_reg, time_out_next;
  logic               lvl_changed_reg, lvl_changed_next;
  logic               game_over_reg, game_over_next;

  logic               tick;
  logic               grant_valid;
  logic [RW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [12:0]        bonus_sum;
  logic [11:0]        bonus_sat;
  logic [3:0]         lives_dec;

  assign tick = (state_reg == S_RUNNING) && (presc_reg == PRESC_LAST);

  // Round-robin search starting at the pointer; first requester found wins.
  always_comb begin
    logic [RW:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_reg} + (RW+1)'(k);
      if (idx >= (RW+1)'(NUM_REQ)) idx = idx - (RW+1)'(NUM_REQ);
      if (!grant_valid && bonus_req[idx[RW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[RW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant_vec[gi] = grant_valid && (grant_idx == RW'(gi));
    end
  endgenerate

  // A bonus absorbs a coincident tick, including the one that would expire the round.
  assign bonus_sum = {1'b0, counter_reg} + BONUS_CNT - {12'd0, tick};
  assign bonus_sat = (bonus_sum > MAX_CNT) ? MAX_CNT[11:0] : bonus_sum[11:0];
  assign lives_dec = (lives_reg == 4'd0) ? 4'd0 : lives_reg - 4'd1;

  always_comb begin
    state_next       = state_reg;
    presc_next       = presc_reg;
    counter_next     = counter_reg;
    lvl_next         = lvl_reg;
    lives_next       = lives_reg;
    ptr_next         = ptr_reg;
    ack_next         = '0;
    time_out_next    = 1'b0;
    lvl_changed_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_RUNNING;
          counter_next = INIT_CNT;
          presc_next   = '0;
        end
      end
      S_RUNNING: begin
        if (level_done) begin
          state_next       = S_LEVEL_UP;
          lvl_next         = (lvl_reg == 10'd1023) ? 10'd1 : lvl_reg + 10'd1;
          counter_next     = INIT_CNT;
          presc_next       = '0;
          lvl_changed_next = 1'b1;
        end else begin
          presc_next = tick ? '0 : presc_reg + PW'(1);
          if (grant_valid) begin
            ack_next     = grant_vec;
            ptr_next     = (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + RW'(1);
            counter_next = bonus_sat;
          end else if (tick && counter_reg == 12'd0) begin
            time_out_next = 1'b1;
            lives_next    = lives_dec;
            presc_next    = '0;
            if (lives_dec == 4'd0) begin
              state_next = S_GAME_OVER;
            end else begin
              state_next   = S_WAIT_RESPAWN;
              counter_next = INIT_CNT;
            end
          end else if (tick) begin
            counter_next = counter_reg - 12'd1;
          end
          if (pause && state_next == S_RUNNING) state_next = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause) state_next = S_RUNNING;
      end
      S_LEVEL_UP: state_next = S_RUNNING;
      S_WAIT_RESPAWN: begin
        if (start) begin
          state_next = S_RUNNING;
          presc_next = '0;
        end
      end
      S_GAME_OVER: begin
        if (start) begin
          state_next   = S_IDLE;
          lvl_next     = 10'd1;
          lives_next   = INIT_LIV;
          counter_next = INIT_CNT;
          presc_next   = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
    game_over_next = (state_next == S_GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      presc_reg       <= '0;
      counter_reg     <= INIT_CNT;
      lvl_reg         <= 10'd1;
      lives_reg       <= INIT_LIV;
      ptr_reg         <= '0;
      ack_reg         <= '0;
      time_out_reg    <= 1'b0;
      lvl_changed_reg <= 1'b0;
      game_over_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= presc_next;
      counter_reg     <= counter_next;
      lvl_reg         <= lvl_next;
      lives_reg       <= lives_next;
      ptr_reg         <= ptr_next;
      ack_reg         <= ack_next;
      time_out_reg    <= time_out_next;
      lvl_changed_reg <= lvl_changed_next;
      game_over_reg   <= game_over_next;
    end
  end

  assign state       = state_reg;
  assign counter     = counter_reg;
  assign lvl         = lvl_reg;
  assign lives       = lives_reg;
  assign bonus_ack   = ack_reg;
  assign time_out    = time_out_reg;
  assign lvl_changed = lvl_changed_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed scenarios plus randomized play, all outputs
// compared every cycle against a transaction-level model of the game rules.
module tb_game_timer_ctrl;
  localparam int TICK_DIV = 4, INIT_TIME = 3, BONUS_TIME = 5, MAX_TIME = 9;
  localparam int INIT_LIVES = 2, NUM_REQ = 2;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, level_done = 1'b0;
  logic [NUM_REQ-1:0] bonus_req = '0;
  logic [NUM_REQ-1:0] bonus_ack;
  logic [9:0]  lvl;
  logic [11:0] counter;
  logic [3:0]  lives;
  logic        time_out, lvl_changed, game_over;
  logic [2:0]  state;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .INIT_TIME(INIT_TIME), .BONUS_TIME(BONUS_TIME),
    .MAX_TIME(MAX_TIME), .INIT_LIVES(INIT_LIVES), .NUM_REQ(NUM_REQ)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .level_done(level_done),
    .bonus_req(bonus_req), .bonus_ack(bonus_ack), .lvl(lvl), .counter(counter),
    .lives(lives), .time_out(time_out), .lvl_changed(lvl_changed),
    .game_over(game_over), .state(state)
  );

  int n_tests = 0, n_fail = 0;
  // Model: game phase (0 idle,1 run,2 paused,3 level-up,4 respawn,5 over), seconds, etc.
  int m_state, m_cnt, m_lvl, m_lives, m_sub, m_ptr, m_ack, m_to, m_lc;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cnt = INIT_TIME; m_lvl = 1; m_lives = INIT_LIVES;
    m_sub = 0; m_ptr = 0; m_ack = 0; m_to = 0; m_lc = 0;
  endfunction

  // One clock of game rules; m_sub counts clocks elapsed within the current second.
  function automatic void model_step();
    int sec_end, winner, i;
    if (!rst) begin
      model_reset();
      return;
    end
    m_ack = 0; m_to = 0; m_lc = 0;
    case (m_state)
      0: if (start) begin m_state = 1; m_cnt = INIT_TIME; m_sub = 0; end
      1: begin
        sec_end = (m_sub == TICK_DIV - 1) ? 1 : 0;
        if (level_done) begin
          m_state = 3; m_lvl = (m_lvl == 1023) ? 1 : m_lvl + 1;
          m_cnt = INIT_TIME; m_sub = 0; m_lc = 1;
        end else begin
          winner = -1;
          for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (winner < 0 && bonus_req[i]) winner = i;
          end
          m_sub = sec_end ? 0 : m_sub + 1;
          if (winner >= 0) begin
            m_ack = 1 << winner;
            m_ptr = (winner + 1) % NUM_REQ;
            m_cnt = m_cnt - sec_end + BONUS_TIME;
            if (m_cnt > MAX_TIME) m_cnt = MAX_TIME;
          end else if (sec_end == 1 && m_cnt == 0) begin
            m_to = 1; m_sub = 0;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            if (m_lives == 0) m_state = 5;
            else begin m_state = 4; m_cnt = INIT_TIME; end
          end else begin
            m_cnt = m_cnt - sec_end;
          end
          if (pause && m_state == 1) m_state = 2;
        end
      end
      2: if (pause) m_state = 1;
      3: m_state = 1;
      4: if (start) begin m_state = 1; m_sub = 0; end
      5: if (start) begin
        m_state = 0; m_lvl = 1; m_lives = INIT_LIVES; m_cnt = INIT_TIME; m_sub = 0;
      end
      default: m_state = 0;
    endcase
  endfunction

  task automatic compare();
    check("state", int'(state), m_state);
    check("counter", int'(counter), m_cnt);
    check("lvl", int'(lvl), m_lvl);
    check("lives", int'(lives), m_lives);
    check("bonus_ack", int'(bonus_ack), m_ack);
    check("time_out", int'(time_out), m_to);
    check("lvl_changed", int'(lvl_changed), m_lc);
    check("game_over", int'(game_over), (m_state == 5) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Advance until the next clock would end a second with zero left (bounded).
  task automatic run_to_expiry(string name);
    int b = 0;
    while (!(m_state == 1 && m_cnt == 0 && m_sub == TICK_DIV - 1) && b < 200) begin
      cycle();
      b++;
    end
    n_tests++;
    if (b >= 200) begin
      n_fail++;
      $display("FAIL %s: expiry point not reached within %0d cycles", name, b);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_counter", int'(counter), 3);
    check("rst_lvl", int'(lvl), 1);
    check("rst_lives", int'(lives), 2);
    check("rst_pulses", int'({time_out, lvl_changed, game_over, bonus_ack}), 0);
    rst = 1'b1;

    // 1: countdown and first expiry
    start = 1'b1; cycle(); start = 1'b0;
    check("t1_state", int'(state), 1);
    check("t1_counter", int'(counter), 3);
    for (int s = 1; s <= 3; s++) begin
      repeat (4) cycle();
      check("t1_step", int'(counter), 3 - s);
    end
    repeat (4) cycle();
    check("t1_time_out", int'(time_out), 1);
    check("t1_lives", int'(lives), 1);
    check("t1_state4", int'(state), 4);
    check("t1_reload", int'(counter), 3);
    cycle();
    check("t1_to_pulse", int'(time_out), 0);

    // 2: last life lost, then new game
    start = 1'b1; cycle(); start = 1'b0;
    repeat (16) cycle();
    check("t2_state5", int'(state), 5);
    check("t2_game_over", int'(game_over), 1);
    check("t2_lives0", int'(lives), 0);
    start = 1'b1; cycle(); start = 1'b0;
    check("t2_idle", int'(state), 0);
    check("t2_lvl", int'(lvl), 1);
    check("t2_lives", int'(lives), 2);
    check("t2_counter", int'(counter), 3);

    // 3: pause freezes the countdown
    start = 1'b1; cycle(); start = 1'b0;
    pause = 1'b1; cycle(); pause = 1'b0;
    repeat (20) cycle();
    check("t3_paused", int'(state), 2);
    check("t3_frozen", int'(counter), 3);
    pause = 1'b1; cycle(); pause = 1'b0;
    check("t3_resumed", int'(state), 1);
    repeat (4) cycle();
    check("t3_counting", int'(counter), 2);

    // 4: two requesters served on consecutive cycles, saturating at MAX_TIME
    level_done = 1'b1; cycle(); level_done = 1'b0;
    cycle();
    bonus_req = 2'b11; cycle();
    check("t4_ack0", int'(bonus_ack), 1);
    check("t4_cnt8", int'(counter), 8);
    cycle(); bonus_req = 2'b00;
    check("t4_ack1", int'(bonus_ack), 2);
    check("t4_cnt9", int'(counter), 9);
    cycle();

    // 5: level_done beats a coincident expiry
    run_to_expiry("t5_reach");
    level_done = 1'b1; cycle(); level_done = 1'b0;
    check("t5_lvl", int'(lvl), 3);
    check("t5_lvl_changed", int'(lvl_changed), 1);
    check("t5_counter", int'(counter), 3);
    check("t5_no_to", int'(time_out), 0);
    check("t5_state3", int'(state), 3);
    cycle();
    check("t5_state1", int'(state), 1);

    // 6: bonus beats a coincident expiry, then asynchronous reset
    run_to_expiry("t6_reach");
    bonus_req = 2'b01; cycle(); bonus_req = 2'b00;
    check("t6_counter", int'(counter), 4);
    check("t6_no_to", int'(time_out), 0);
    check("t6_ack", int'(bonus_ack), 1);
    cycle(); cycle();
    #2 rst = 1'b0;
    #1;
    check("t6_async_state", int'(state), 0);
    check("t6_async_counter", int'(counter), 3);
    check("t6_async_lvl", int'(lvl), 1);
    check("t6_async_lives", int'(lives), 2);
    model_reset();
    cycle();
    rst = 1'b1;

    // randomized play
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(7) == 0);
      pause      = ($urandom_range(15) == 0);
      level_done = ($urandom_range(31) == 0);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (m_ack[r]) bonus_req[r] = 1'b0;
        else if (!bonus_req[r] && $urandom_range(5) == 0) bonus_req[r] = 1'b1;
      end
      if ($urandom_range(599) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      cycle();
    end

    // level wrap 1023 -> 1
    start = 1'b0; pause = 1'b0; level_done = 1'b0; bonus_req = '0;
    rst = 1'b0; model_reset(); cycle(); rst = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    for (int n = 0; n < 1022; n++) begin
      level_done = 1'b1; cycle(); level_done = 1'b0; cycle();
    end
    check("wrap_1023", int'(lvl), 1023);
    level_done = 1'b1; cycle(); level_done = 1'b0;
    check("wrap_to_1", int'(lvl), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
Round/timer sequencer for the game core. It owns the level countdown, the level number and the lives count. It generates its own 1 Hz tick from the system clock by clock-enable, with no derived clock. It arbitrates bonus-time requests from several game objects, then sequences start, pause, level-up, time-out and game-over for the display and game-logic blocks.

Parameters:
TICK_DIV, 100_000_000, system clock cycles per countdown tick (1 s at 100 MHz)
INIT_TIME, 60, countdown value loaded at start, level change and respawn (seconds)
BONUS_TIME, 5, seconds added per granted bonus request
MAX_TIME, 999, saturation ceiling for the counter
INIT_LIVES, 3, lives loaded at reset and on new game
NUM_REQ, 4, number of bonus requesters

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
start  in  1  level-sensitive start/continue request, sampled in IDLE and WAIT_RESPAWN
pause  in  1  toggle request, one-cycle pulse
level_done  in  1  one-cycle pulse, player finished level
bonus_req  in  NUM_REQ  per-requester bonus request, held until acked
bonus_ack  out  NUM_REQ  one-hot grant pulse, one cycle
lvl  out  10  current level, starts at 1
counter  out  12  seconds remaining
lives  out  4  lives remaining
time_out  out  1  one-cycle pulse when countdown expires
lvl_changed  out  1  one-cycle pulse on level increment
game_over  out  1  high while in GAME_OVER
state  out  3  encoded FSM state for debug/display

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=INIT_TIME, lvl=1, lives=INIT_LIVES, prescaler=0, RR pointer=0. All pulse outputs are 0 and game_over=0.
- States: IDLE=0, RUNNING=1, PAUSED=2, LEVEL_UP=3, WAIT_RESPAWN=4, GAME_OVER=5.
- IDLE: start=1 -> RUNNING. Counter=INIT_TIME and prescaler=0 on entry.
- RUNNING:
  - Prescaler counts 0..TICK_DIV-1. Tick is asserted in the cycle the prescaler equals TICK_DIV-1, after which it wraps to 0.
  - Tick with counter>0: counter-1.
  - Tick with counter==0: time_out=1 next cycle and lives-1.
    - If the new lives value is 0 -> GAME_OVER.
    - Otherwise -> WAIT_RESPAWN, with counter=INIT_TIME.
- PAUSED: pause pulse in RUNNING -> PAUSED; pause pulse in PAUSED -> RUNNING. Prescaler and counter are frozen and bonus requests are not granted.
- level_done in RUNNING -> LEVEL_UP. lvl+1, wrapping 1023 -> 1. Counter=INIT_TIME, prescaler=0, lvl_changed pulses for 1 cycle. LEVEL_UP -> RUNNING unconditionally after 1 cycle.
- WAIT_RESPAWN: start=1 -> RUNNING with prescaler=0.
- GAME_OVER: game_over=1. start=1 -> IDLE with lvl=1, lives=INIT_LIVES, counter=INIT_TIME.
- Priority within one RUNNING cycle: level_done > tick-expiry > pause. A level_done takes precedence over a simultaneous tick, and no time_out is produced.
- Bonus arbitration (RUNNING only):
  - Round-robin, at most one grant per cycle. The search starts at the RR pointer; after a grant to index i, pointer = (i+1) mod NUM_REQ.
  - Grant: bonus_ack[i]=1 for 1 cycle and counter += BONUS_TIME, saturating at MAX_TIME.
  - Requesters drop their request after the ack. A request still high the cycle after its ack is treated as a new request.
- Bonus coinciding with a decrement tick: counter = min(counter - 1 + BONUS_TIME, MAX_TIME).
- Bonus coinciding with a tick at counter==0: the bonus wins. Counter = min(BONUS_TIME - 1, MAX_TIME) with BONUS_TIME ≥ 1, and there is no time_out.
- Bonus requests in any state other than RUNNING are held off, with no ack.
- Width rules: counter arithmetic is 13-bit internally before saturation. Counter never underflows. lives never goes below 0.
- Latency: all outputs are registered; a control input takes effect on the next rising edge.
- Reset mid-operation forces the reset values immediately, regardless of state.

Test Plan:
Test parameters for all scenarios: TICK_DIV=4, INIT_TIME=3, BONUS_TIME=5, MAX_TIME=9, INIT_LIVES=2, NUM_REQ=2.
1. Reset, then start for 1 cycle -> state=1, counter=3. Counter steps 3,2,1,0 every 4 cycles. The next tick gives time_out for 1 cycle, lives=1, state=4, counter=3.
2. Continue from 1: start, then let the counter expire again -> lives=0, state=5, game_over=1. Then start -> state=0, lvl=1, lives=2, counter=3.
3. RUNNING at counter=3, pause pulse, wait 20 cycles -> counter stays 3, state=2. Pause again -> the countdown resumes after 4 cycles.
4. bonus_req=2'b11 held, counter=3 -> ack 01 then 10 on consecutive cycles. Counter goes 8 then 9, saturated.
5. level_done coincident with a tick at counter==0 -> lvl=2, lvl_changed=1, counter=3, no time_out, state 3 then 1.
6. bonus_req[0] asserted on the tick cycle at counter==0 -> counter=4, no time_out. Separately, rst=0 asserted mid-RUNNING -> all outputs return to reset values asynchronously.
